wb: RTL and testbench

WB -- requirements
Module: wb

---
 rtl/wb.sv | 120 ++++++++++++
 tb/tb_wb.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb.sv
// Writeback/fetch glue: pipeline stall and bubble generation, fetch PC hold,
// store byte-lane formatting and load extraction with sign/zero extension.
module wb #(
   parameter logic [31:0] RESET = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall_read_i,
   input  logic [31:0] fetch_pc_i,
   input  logic        wb_branch_i,
   input  logic        wb_mem_to_reg_i,
   input  logic        mem_write_i,
   input  logic [31:0] write_address_i,
   input  logic [31:0] alu_operand2_i,
   input  logic [2:0]  alu_operation_i,
   input  logic [2:0]  wb_alu_operation_i,
   input  logic [1:0]  wb_read_address_i,
   input  logic [31:0] dmem_read_data_i,
   input  logic        dmem_write_valid_i,
   output logic [31:0] inst_mem_address_o,
   output logic        inst_mem_is_ready_o,
   output logic        wb_stall_o,
   output logic [31:0] wb_write_address_o,
   output logic [31:0] wb_write_data_o,
   output logic [3:0]  wb_write_byte_o,
   output logic [31:0] wb_read_data_o,
   output logic [31:0] inst_fetch_pc_o,
   output logic        wb_stall_first_o,
   output logic        wb_stall_second_o
);

   localparam int unsigned XLEN = 32;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   // A store the memory cannot accept blocks the pipeline just like a read stall.
   assign wb_stall_o = stall_read_i | (mem_write_i & ~dmem_write_valid_i);

   // While stalled, fetch replays the held PC instead of the new one.
   assign inst_mem_address_o = wb_stall_o ? inst_fetch_pc_o : fetch_pc_i;

   assign wb_write_address_o = {write_address_i[XLEN-1:2], 2'b00};

   // Fetch PC register, fetch-enable and the two-deep bubble shift chain.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         inst_fetch_pc_o     <= RESET;
         inst_mem_is_ready_o <= 1'b0;
         wb_stall_first_o    <= 1'b0;
         wb_stall_second_o   <= 1'b0;
      end else begin
         if (!wb_stall_o) begin
            inst_fetch_pc_o <= fetch_pc_i;
         end
         inst_mem_is_ready_o <= ~wb_stall_o;
         wb_stall_first_o    <= wb_stall_o | wb_branch_i;
         wb_stall_second_o   <= wb_stall_first_o;
      end
   end

   // Store formatting: replicate data across lanes, enable only the addressed ones.
   always_comb begin
      wb_write_data_o = alu_operand2_i;
      wb_write_byte_o = 4'b0000;
      if (mem_write_i) begin
         case (alu_operation_i)
            F3_B: begin
               wb_write_data_o = {4{alu_operand2_i[7:0]}};
               wb_write_byte_o = 4'b0001 << write_address_i[1:0];
            end
            F3_H: begin
               wb_write_data_o = {2{alu_operand2_i[15:0]}};
               wb_write_byte_o = write_address_i[1] ? 4'b1100 : 4'b0011;
            end
            F3_W: begin
               wb_write_data_o = alu_operand2_i;
               wb_write_byte_o = 4'b1111;
            end
            default: begin
               wb_write_data_o = alu_operand2_i;
               wb_write_byte_o = 4'b0000;
            end
         endcase
      end
      if (!reset) begin
         wb_write_byte_o = 4'b0000;
      end
   end

   // Load extraction: pick lane by offset, then extend per funct3.
   always_comb begin
      case (wb_read_address_i)
         2'd0:    ld_byte = dmem_read_data_i[7:0];
         2'd1:    ld_byte = dmem_read_data_i[15:8];
         2'd2:    ld_byte = dmem_read_data_i[23:16];
         default: ld_byte = dmem_read_data_i[31:24];
      endcase
      ld_half = wb_read_address_i[1] ? dmem_read_data_i[31:16] : dmem_read_data_i[15:0];

      wb_read_data_o = '0;
      if (wb_mem_to_reg_i) begin
         case (wb_alu_operation_i)
            F3_B:    wb_read_data_o = {{24{ld_byte[7]}}, ld_byte};
            F3_H:    wb_read_data_o = {{16{ld_half[15]}}, ld_half};
            F3_W:    wb_read_data_o = dmem_read_data_i;
            F3_BU:   wb_read_data_o = {24'd0, ld_byte};
            F3_HU:   wb_read_data_o = {16'd0, ld_half};
            default: wb_read_data_o = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_wb.sv
// Scoreboard bench for wb: a reference model predicts every output per cycle,
// a monitor on the falling edge pops predictions and compares.
module tb_wb;

   typedef struct {
      logic        reset;
      logic        sr;
      logic [31:0] fpc;
      logic        br;
      logic        m2r;
      logic        mw;
      logic [31:0] waddr;
      logic [31:0] op2;
      logic [2:0]  sf3;
      logic [2:0]  lf3;
      logic [1:0]  roff;
      logic [31:0] rdata;
      logic        dv;
   } stim_t;

   typedef struct {
      string       name;
      logic        stall;
      logic [31:0] iaddr;
      logic        ready;
      logic [31:0] pc;
      logic        first;
      logic        second;
      logic [31:0] waddr;
      logic [31:0] wdata;
      logic [3:0]  wbyte;
      logic [31:0] rdata;
   } exp_t;

   logic        clk;
   logic        reset;
   logic        stall_read_i;
   logic [31:0] fetch_pc_i;
   logic        wb_branch_i;
   logic        wb_mem_to_reg_i;
   logic        mem_write_i;
   logic [31:0] write_address_i;
   logic [31:0] alu_operand2_i;
   logic [2:0]  alu_operation_i;
   logic [2:0]  wb_alu_operation_i;
   logic [1:0]  wb_read_address_i;
   logic [31:0] dmem_read_data_i;
   logic        dmem_write_valid_i;
   logic [31:0] inst_mem_address_o;
   logic        inst_mem_is_ready_o;
   logic        wb_stall_o;
   logic [31:0] wb_write_address_o;
   logic [31:0] wb_write_data_o;
   logic [3:0]  wb_write_byte_o;
   logic [31:0] wb_read_data_o;
   logic [31:0] inst_fetch_pc_o;
   logic        wb_stall_first_o;
   logic        wb_stall_second_o;

   localparam logic [31:0] RST_PC = 32'h0000_0000;

   wb #(.RESET(RST_PC)) dut (
      .clk                (clk),
      .reset              (reset),
      .stall_read_i       (stall_read_i),
      .fetch_pc_i         (fetch_pc_i),
      .wb_branch_i        (wb_branch_i),
      .wb_mem_to_reg_i    (wb_mem_to_reg_i),
      .mem_write_i        (mem_write_i),
      .write_address_i    (write_address_i),
      .alu_operand2_i     (alu_operand2_i),
      .alu_operation_i    (alu_operation_i),
      .wb_alu_operation_i (wb_alu_operation_i),
      .wb_read_address_i  (wb_read_address_i),
      .dmem_read_data_i   (dmem_read_data_i),
      .dmem_write_valid_i (dmem_write_valid_i),
      .inst_mem_address_o (inst_mem_address_o),
      .inst_mem_is_ready_o(inst_mem_is_ready_o),
      .wb_stall_o         (wb_stall_o),
      .wb_write_address_o (wb_write_address_o),
      .wb_write_data_o    (wb_write_data_o),
      .wb_write_byte_o    (wb_write_byte_o),
      .wb_read_data_o     (wb_read_data_o),
      .inst_fetch_pc_o    (inst_fetch_pc_o),
      .wb_stall_first_o   (wb_stall_first_o),
      .wb_stall_second_o  (wb_stall_second_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int    vectors = 0;
   int    errors  = 0;
   exp_t  sb[$];
   stim_t cur;

   // Reference model state
   logic [31:0] m_pc;
   logic        m_ready, m_first, m_second;

   function automatic logic m_stall(input stim_t s);
      return s.sr || (s.mw && !s.dv);
   endfunction

   function automatic logic [31:0] m_load(input stim_t s);
      logic [31:0] b, h;
      if (!s.m2r) return 32'h0;
      b = (s.rdata >> (8 * s.roff)) & 32'hFF;
      h = (s.rdata >> (16 * s.roff[1])) & 32'hFFFF;
      case (s.lf3)
         3'd0:    return (b > 32'd127)   ? b + 32'hFFFF_FF00 : b;
         3'd1:    return (h > 32'd32767) ? h + 32'hFFFF_0000 : h;
         3'd2:    return s.rdata;
         3'd4:    return b;
         3'd5:    return h;
         default: return 32'h0;
      endcase
   endfunction

   task automatic m_store(input stim_t s, output logic [31:0] d, output logic [3:0] be);
      d  = s.op2;
      be = 4'd0;
      if (s.mw) begin
         if (s.sf3 == 3'd0) begin
            d  = (s.op2 & 32'hFF) * 32'h0101_0101;
            be = 4'(1 << s.waddr[1:0]);
         end else if (s.sf3 == 3'd1) begin
            d  = (s.op2 & 32'hFFFF) * 32'h0001_0001;
            be = s.waddr[1] ? 4'd12 : 4'd3;
         end else if (s.sf3 == 3'd2) begin
            be = 4'd15;
         end
      end
      if (!s.reset) be = 4'd0;
   endtask

   task automatic drive(input stim_t s);
      reset              = s.reset;
      stall_read_i       = s.sr;
      fetch_pc_i         = s.fpc;
      wb_branch_i        = s.br;
      wb_mem_to_reg_i    = s.m2r;
      mem_write_i        = s.mw;
      write_address_i    = s.waddr;
      alu_operand2_i     = s.op2;
      alu_operation_i    = s.sf3;
      wb_alu_operation_i = s.lf3;
      wb_read_address_i  = s.roff;
      dmem_read_data_i   = s.rdata;
      dmem_write_valid_i = s.dv;
   endtask

   // One cycle: advance model on the edge, apply new stimulus, push prediction.
   task automatic step(input stim_t s, input string name);
      exp_t e;
      logic st;
      @(posedge clk);
      if (cur.reset) begin
         st       = m_stall(cur);
         m_second = m_first;
         m_first  = st || cur.br;
         m_ready  = !st;
         if (!st) m_pc = cur.fpc;
      end
      #1;
      cur = s;
      drive(s);
      if (!s.reset) begin
         m_pc = RST_PC; m_ready = 1'b0; m_first = 1'b0; m_second = 1'b0;
      end
      e.name   = name;
      e.stall  = m_stall(s);
      e.iaddr  = e.stall ? m_pc : s.fpc;
      e.ready  = m_ready;
      e.pc     = m_pc;
      e.first  = m_first;
      e.second = m_second;
      e.waddr  = s.waddr & 32'hFFFF_FFFC;
      m_store(s, e.wdata, e.wbyte);
      e.rdata  = m_load(s);
      sb.push_back(e);
   endtask

   task automatic chk(input string name, input string field, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s.%s: got %h expected %h at %0t", name, field, act, exp, $time);
      end
   endtask

   // Monitor: compare every pending prediction against DUT outputs mid-cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk(e.name, "stall",  32'(wb_stall_o),          32'(e.stall));
            chk(e.name, "iaddr",  inst_mem_address_o,       e.iaddr);
            chk(e.name, "ready",  32'(inst_mem_is_ready_o), 32'(e.ready));
            chk(e.name, "pc",     inst_fetch_pc_o,          e.pc);
            chk(e.name, "first",  32'(wb_stall_first_o),    32'(e.first));
            chk(e.name, "second", 32'(wb_stall_second_o),   32'(e.second));
            chk(e.name, "waddr",  wb_write_address_o,       e.waddr);
            chk(e.name, "wbyte",  32'(wb_write_byte_o),     32'(e.wbyte));
            if (e.wbyte != 4'd0) chk(e.name, "wdata", wb_write_data_o, e.wdata);
            chk(e.name, "rdata",  wb_read_data_o,           e.rdata);
         end
      end
   end

   function automatic stim_t idle(input logic [31:0] pc);
      stim_t s;
      s = '{reset: 1'b1, sr: 1'b0, fpc: pc, br: 1'b0, m2r: 1'b0, mw: 1'b0,
            waddr: 32'h0, op2: 32'h0, sf3: 3'd0, lf3: 3'd0, roff: 2'd0,
            rdata: 32'h0, dv: 1'b1};
      return s;
   endfunction

   initial begin
      stim_t s;
      cur = idle(32'h0);
      cur.reset = 1'b0;
      cur.fpc   = 32'h0;
      drive(cur);
      m_pc = RST_PC; m_ready = 1'b0; m_first = 1'b0; m_second = 1'b0;

      s = cur;
      step(s, "rst0");
      step(s, "rst1");
      s = idle(32'h0000_0004); step(s, "rel");
      s = idle(32'h0000_0008); step(s, "run");

      s = idle(32'h0000_000C); s.mw = 1'b1; s.sf3 = 3'd0; s.waddr = 32'h1003; s.op2 = 32'h0000_00A5;
      step(s, "sb");
      s = idle(32'h0000_0010); s.mw = 1'b1; s.sf3 = 3'd1; s.waddr = 32'h2002; s.op2 = 32'h1234_BEEF;
      step(s, "sh");
      s = idle(32'h0000_0014); s.mw = 1'b1; s.sf3 = 3'd2; s.waddr = 32'h2001; s.op2 = 32'h1234_BEEF;
      step(s, "sw");
      s = idle(32'h0000_0018); s.mw = 1'b1; s.sf3 = 3'd3; s.waddr = 32'h2001;
      step(s, "sbad");

      s = idle(32'h0000_001C); s.m2r = 1'b1; s.rdata = 32'h80F0_7F11;
      s.lf3 = 3'd0; s.roff = 2'd3; step(s, "lb");
      s.lf3 = 3'd4; s.roff = 2'd2; step(s, "lbu");
      s.lf3 = 3'd1; s.roff = 2'd2; step(s, "lh");
      s.lf3 = 3'd5; s.roff = 2'd0; step(s, "lhu");
      s.lf3 = 3'd2; s.roff = 2'd1; step(s, "lw");
      s.lf3 = 3'd7; step(s, "lbad");
      s.lf3 = 3'd2; s.m2r = 1'b0; step(s, "lnone");

      s = idle(32'h0000_0100); step(s, "pre");
      s = idle(32'h0000_0104); s.mw = 1'b1; s.sf3 = 3'd2; s.dv = 1'b0; step(s, "stall");
      s = idle(32'h0000_0108); step(s, "post0");
      s = idle(32'h0000_010C); step(s, "post1");
      s = idle(32'h0000_0110); step(s, "post2");

      s = idle(32'h0000_0200); s.br = 1'b1; step(s, "br");
      s = idle(32'h0000_0204); step(s, "br1");
      s = idle(32'h0000_0208); step(s, "br2");
      s = idle(32'h0000_020C); step(s, "br3");

      s = idle(32'h0000_0300); s.br = 1'b1; s.sr = 1'b1; step(s, "stbr");
      s = idle(32'h0000_0304); s.sr = 1'b1; step(s, "st2");
      s.reset = 1'b0; step(s, "midrst");
      s = idle(32'h0000_0308); step(s, "rel2");
      step(s, "run2");

      for (int i = 0; i < 400; i++) begin
         s.reset = ($urandom_range(0, 49) != 0);
         s.sr    = ($urandom_range(0, 4) == 0);
         s.fpc   = $urandom;
         s.br    = ($urandom_range(0, 5) == 0);
         s.m2r   = ($urandom_range(0, 3) != 0);
         s.mw    = 1'($urandom_range(0, 1));
         s.waddr = $urandom;
         s.op2   = $urandom;
         s.sf3   = 3'($urandom_range(0, 7));
         s.lf3   = 3'($urandom_range(0, 7));
         s.roff  = 2'($urandom_range(0, 3));
         s.rdata = $urandom;
         s.dv    = ($urandom_range(0, 3) != 0);
         step(s, "rnd");
      end

      repeat (3) @(posedge clk);
      vectors++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expected 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
